// File: rtl/sys_bus_arbiter_if.sv
// Bus bundle for sys_bus_arbiter: I-cache and D-cache request channels,
// shared completion signals and the single memory port.
interface sys_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_sys_strobe;
    logic          i_sys_rw;
    logic [AW-1:0] i_sys_addr;
    logic [DW-1:0] i_sys_wdata;
    logic          i_sys_ready;

    logic          d_sys_strobe;
    logic          d_sys_rw;
    logic [AW-1:0] d_sys_addr;
    logic [DW-1:0] d_sys_wdata;
    logic          d_sys_ready;

    logic [DW-1:0] sys_rdata;
    logic          sys_error;

    logic          mem_strobe;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Arbiter side: takes both requests and the memory response, drives the rest.
    modport slave (
        input  i_sys_strobe, i_sys_rw, i_sys_addr, i_sys_wdata,
        input  d_sys_strobe, d_sys_rw, d_sys_addr, d_sys_wdata,
        input  mem_rdata, mem_ready,
        output i_sys_ready, d_sys_ready, sys_rdata, sys_error,
        output mem_strobe, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output i_sys_strobe, i_sys_rw, i_sys_addr, i_sys_wdata,
        output d_sys_strobe, d_sys_rw, d_sys_addr, d_sys_wdata,
        output mem_rdata, mem_ready,
        input  i_sys_ready, d_sys_ready, sys_rdata, sys_error,
        input  mem_strobe, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Shares one memory port between the I-cache and D-cache controllers, with a per-transaction timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise D always wins simultaneous requests.
module sys_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst_n,
    sys_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t        state_r, state_s;
    logic          own_r, own_s;
    logic [7:0]    tcnt_r, tcnt_s;
    logic          mem_strobe_r, mem_strobe_s;
    logic          mem_rw_r, mem_rw_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic [DW-1:0] sys_rdata_r, sys_rdata_s;
    logic          sys_error_r, sys_error_s;
    logic          win_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_r, last_s;

    // Winner select: on a tie, the requester not granted last (1 = D).
    always_comb begin
        if (bus.i_sys_strobe && bus.d_sys_strobe) begin
            win_s = ~last_r;
        end else begin
            win_s = bus.d_sys_strobe;
        end
    end

    // Last-grant register; reset to D so the first tie goes to I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_s;
        end
    end
`else
    // Winner select: fixed priority, D over I.
    always_comb begin
        win_s = bus.d_sys_strobe;
    end
`endif

    // Next-state and next-register logic for the arbitration FSM.
    always_comb begin
        state_s      = state_r;
        own_s        = own_r;
        tcnt_s       = tcnt_r;
        mem_strobe_s = mem_strobe_r;
        mem_rw_s     = mem_rw_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        sys_rdata_s  = sys_rdata_r;
        sys_error_s  = sys_error_r;
`ifdef ARB_ROUND_ROBIN_EN
        last_s       = last_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.i_sys_strobe || bus.d_sys_strobe) begin
                    own_s        = win_s;
                    tcnt_s       = 8'd0;
                    mem_strobe_s = 1'b1;
                    state_s      = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    last_s       = win_s;
`endif
                    if (win_s) begin
                        mem_rw_s    = bus.d_sys_rw;
                        mem_addr_s  = bus.d_sys_addr;
                        mem_wdata_s = bus.d_sys_wdata;
                    end else begin
                        mem_rw_s    = bus.i_sys_rw;
                        mem_addr_s  = bus.i_sys_addr;
                        mem_wdata_s = bus.i_sys_wdata;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // A memory answer in the last allowed cycle still beats the timeout.
                if (bus.mem_ready) begin
                    if (mem_rw_r) begin
                        sys_rdata_s = bus.mem_rdata;
                    end else begin
                        sys_rdata_s = sys_rdata_r;
                    end
                    sys_error_s  = 1'b0;
                    mem_strobe_s = 1'b0;
                    state_s      = DONE;
                end else if (tcnt_r == TCNT_LAST) begin
                    sys_rdata_s  = {DW{1'b0}};
                    sys_error_s  = 1'b1;
                    mem_strobe_s = 1'b0;
                    state_s      = DONE;
                end else begin
                    tcnt_s = tcnt_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s      = IDLE;
                mem_strobe_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            own_r        <= 1'b0;
            tcnt_r       <= 8'd0;
            mem_strobe_r <= 1'b0;
            mem_rw_r     <= 1'b1;
            mem_addr_r   <= {AW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            sys_rdata_r  <= {DW{1'b0}};
            sys_error_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            own_r        <= own_s;
            tcnt_r       <= tcnt_s;
            mem_strobe_r <= mem_strobe_s;
            mem_rw_r     <= mem_rw_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            sys_rdata_r  <= sys_rdata_s;
            sys_error_r  <= sys_error_s;
        end
    end

    // Ready pulses are decoded straight from DONE and the owner.
    assign bus.i_sys_ready = (state_r == DONE) && !own_r;
    assign bus.d_sys_ready = (state_r == DONE) &&  own_r;
    assign bus.sys_rdata   = sys_rdata_r;
    assign bus.sys_error   = sys_error_r;
    assign bus.mem_strobe  = mem_strobe_r;
    assign bus.mem_rw      = mem_rw_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;

endmodule
